// File: rtl/run_sequencer.sv
// Run controller: holds cores in reset, runs them while counting cycles, ends on all-halt or budget expiry.
// Optional per-core halt timestamps enabled by defining RUN_SEQ_HALT_STAMP_EN.
module run_sequencer #(
   parameter int N_CORES      = 1,
   parameter int CNT_W        = 32,
   parameter int RESET_CYCLES = 5,
   parameter int MAX_CYCLES   = 20
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [N_CORES-1:0]       halt_i,
   output logic [N_CORES-1:0]       core_reset_o,
   output logic                     run_o,
   output logic [CNT_W-1:0]         cycle_cnt_o,
   output logic [N_CORES-1:0]       halted_mask_o,
   output logic                     done_o,
`ifdef RUN_SEQ_HALT_STAMP_EN
   output logic [N_CORES*CNT_W-1:0] halt_cycle_o,
`endif
   output logic                     timeout_o
);

   localparam int              RC_W     = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
   localparam logic [RC_W-1:0] RC_LAST  = RC_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);
   localparam bit              TO_EN    = (MAX_CYCLES != 0);

   typedef enum logic [1:0] {S_IDLE, S_RST, S_RUN, S_DONE} state_t;

   state_t             r_state;
   logic [RC_W-1:0]    r_rcnt;
   logic [N_CORES-1:0] r_core_rst;
   logic               r_run;
   logic [CNT_W-1:0]   r_cnt;
   logic [N_CORES-1:0] r_mask;
   logic               r_done;
   logic               r_timeout;
`ifdef RUN_SEQ_HALT_STAMP_EN
   logic [N_CORES*CNT_W-1:0] r_stamp;
`endif

   logic [N_CORES-1:0] w_mask_next;
   logic               w_all_halted;
   logic               w_budget_out;
   logic [CNT_W-1:0]   w_cnt_next;

   always_comb begin
      w_mask_next  = r_mask | halt_i;
      w_all_halted = &w_mask_next;
      w_budget_out = TO_EN && (r_cnt == CNT_LAST);
      // Saturate rather than wrap so a long untimed run never reads as short.
      w_cnt_next   = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_rcnt     <= '0;
         r_core_rst <= '1;
         r_run      <= 1'b0;
         r_cnt      <= '0;
         r_mask     <= '0;
         r_done     <= 1'b0;
         r_timeout  <= 1'b0;
`ifdef RUN_SEQ_HALT_STAMP_EN
         r_stamp    <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_state    <= S_RST;
                  r_rcnt     <= '0;
                  r_core_rst <= '1;
                  r_run      <= 1'b0;
                  r_cnt      <= '0;
                  r_mask     <= '0;
                  r_done     <= 1'b0;
                  r_timeout  <= 1'b0;
`ifdef RUN_SEQ_HALT_STAMP_EN
                  r_stamp    <= '0;
`endif
               end
            end
            S_RST: begin
               if (r_rcnt == RC_LAST) begin
                  r_state    <= S_RUN;
                  r_core_rst <= '0;
                  r_run      <= 1'b1;
               end else begin
                  r_rcnt <= r_rcnt + RC_W'(1);
               end
            end
            S_RUN: begin
               r_mask <= w_mask_next;
               r_cnt  <= w_cnt_next;
`ifdef RUN_SEQ_HALT_STAMP_EN
               for (int unsigned i = 0; i < N_CORES; i++) begin
                  if (halt_i[i] && !r_mask[i])
                     r_stamp[i*CNT_W +: CNT_W] <= r_cnt;
               end
`endif
               // All-halt takes priority over budget expiry at the same edge.
               if (w_all_halted || w_budget_out) begin
                  r_state   <= S_DONE;
                  r_run     <= 1'b0;
                  r_done    <= 1'b1;
                  r_timeout <= !w_all_halted;
               end
            end
            default: begin
               r_state    <= S_IDLE;
               r_core_rst <= '1;
               r_run      <= 1'b0;
               r_done     <= 1'b0;
            end
         endcase
      end
   end

   assign core_reset_o  = r_core_rst;
   assign run_o         = r_run;
   assign cycle_cnt_o   = r_cnt;
   assign halted_mask_o = r_mask;
   assign done_o        = r_done;
   assign timeout_o     = r_timeout;
`ifdef RUN_SEQ_HALT_STAMP_EN
   assign halt_cycle_o  = r_stamp;
`endif

endmodule

// File: doc/run_sequencer.md
Name: run_sequencer

Overview:
- Synthesizable run controller that drives one or more CPU cores under test.
- Holds the cores in reset for a programmable number of cycles, then lets them run while counting cycles.
- Ends the run when every core reports halt, or when the cycle budget expires.
- Sits between bench/board top and the mips core instances; replaces the hand-timed reset/finish sequencing with a parametrised, multi-core, halt-aware controller.

Parameters:
- N_CORES, 1, number of cores sequenced; width of the per-core vectors.
- CNT_W, 32, width of the cycle counter.
- RESET_CYCLES, 5, clock cycles core_reset_o is held high after start; must be ≥1.
- MAX_CYCLES, 20, run budget in cycles; 0 = no timeout.

Ports:
- clk  in  1  system clock, all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset of this block.
- start  in  1  single-cycle request to begin/restart a run; honoured in IDLE and DONE only.
- halt_i  in  N_CORES  per-core halt indication, level, sampled only in RUN.
- core_reset_o  out  N_CORES  active-high synchronous reset to each core.
- run_o  out  1  core clock-enable; high only in RUN.
- cycle_cnt_o  out  CNT_W  cycles elapsed in RUN.
- halted_mask_o  out  N_CORES  sticky per-core halted flags.
- done_o  out  1  run finished; high in DONE.
- timeout_o  out  1  run ended by budget expiry; valid while done_o=1.

Behaviour:
- Reset is asynchronous and active-low; the port is named reset, matching the codebase's reset port name.
- While reset=0:
  - state=IDLE
  - core_reset_o=all 1
  - run_o=0, done_o=0, timeout_o=0
  - cycle_cnt_o=0, halted_mask_o=0
  - internal reset counter=0
- States: IDLE, RST, RUN, DONE; all outputs registered.
- IDLE:
  - core_reset_o all 1, run_o=0.
  - start=1 at an edge → RST.
  - On entering RST: clear cycle_cnt_o, halted_mask_o, done_o, timeout_o, reset counter.
- RST:
  - core_reset_o all 1 for exactly RESET_CYCLES cycles (the reset counter counts 0..RESET_CYCLES-1).
  - At the edge where the counter is RESET_CYCLES-1 → RUN.
  - start is ignored.
- RUN:
  - core_reset_o all 0, run_o=1.
  - cycle_cnt_o is 0 in the first RUN cycle and increments by 1 at each RUN edge.
  - Each edge: halted_mask_o |= halt_i. Flags are sticky; deassertion of halt_i does not clear them.
  - All-halted condition: (halted_mask_o | halt_i) == all ones at an edge → DONE with timeout_o=0.
  - Timeout condition: MAX_CYCLES≠0, cycle_cnt_o==MAX_CYCLES-1 at an edge, all-halted condition false → DONE with timeout_o=1.
  - Both conditions at the same edge: halt wins, timeout_o=0.
  - start is ignored.
  - cycle_cnt_o saturates at all ones; it never wraps.
- DONE:
  - run_o=0, core_reset_o all 0 (cores frozen by run_o, state preserved for inspection).
  - done_o=1; cycle_cnt_o, halted_mask_o and timeout_o hold.
  - start=1 → RST, which clears the flags as above.
- Latency:
  - start to first RUN cycle = RESET_CYCLES+1 edges.
  - The last halting core's halt_i to done_o = 1 edge.
- Reset asserted mid-run: immediate return to IDLE values regardless of state; no partial flags survive.

Optional Feature:
- Macro RUN_SEQ_HALT_STAMP_EN.
- When defined:
  - Adds output port halt_cycle_o, width N_CORES*CNT_W.
  - Slice i captures cycle_cnt_o at the edge where halted_mask_o[i] first sets.
  - Cleared to 0 by reset and on entry to RST; holds in DONE.
  - Slices for cores that never halted remain 0.
- When not defined: the port and its registers do not exist; all other behaviour is identical.

Test Plan:
- Reset hold and reset cycles: reset=0 for 3 cycles, then release; N_CORES=1, RESET_CYCLES=5; pulse start at edge 0. Required response:
  - All outputs at reset values while reset=0.
  - core_reset_o=1 through edge 5.
  - run_o=1 from edge 6 with cycle_cnt_o=0.
- Halt ends run: N_CORES=2, MAX_CYCLES=20. Core0 halt at cycle_cnt 3, core1 halt at cycle_cnt 7; drop halt_i[0] at 5. Required response:
  - halted_mask_o=2'b01 after cycle 3, held through cycle 5 despite the drop.
  - done_o=1, timeout_o=0, cycle_cnt_o=8 after the edge at cycle 7.
- Timeout: no halts, MAX_CYCLES=20. Required response: done_o=1, timeout_o=1, cycle_cnt_o=20, run_o=0.
- Simultaneous halt and timeout: halt_i all 1 exactly at cycle_cnt 19, MAX_CYCLES=20. Required response: done_o=1, timeout_o=0.
- Reset mid-run and restart: reset=0 at cycle_cnt 4 → immediate IDLE values.
  - Start during RUN is ignored.
  - Start in DONE restarts: flags clear, RST lasts 5 cycles again.
- RUN_SEQ_HALT_STAMP_EN: N_CORES=2, core1 halt at 7, core0 at 9. Required response:
  - halt_cycle_o = {7, 9}.
  - After restart, both slices read 0.
